// File: rtl/edge_pkg.sv
// Shared constants and types for the SPI frame loader: command bytes,
// loader states, error bit positions and default image geometry.
package edge_pkg;

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_CLRERR = 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, LOAD, DRAIN, START, BUSY} loader_state_t;

  localparam int ERR_BAD_CMD     = 0;
  localparam int ERR_SHORT_FRAME = 1;
  localparam int ERR_BUSY_CMD    = 2;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int NPIX      = IMG_W_DEF * IMG_H_DEF;

endpackage

// File: rtl/spi_frame_loader.sv
// Command sequencer between the SPI byte receiver and the frame buffer; owns buffer arbitration.
// Pixel writes land one cycle after their byte strobe; no backpressure, bytes outside LOAD are dropped.
module spi_frame_loader
  import edge_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cs,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              accel_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              buf_sel,
  output logic              accel_start,
  output logic              frame_valid,
  output logic [2:0]        err
);

  localparam int                PIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX - 1);

  loader_state_t     state;
  logic              csQ;
  logic              busyArmed;
  logic [ADDR_W-1:0] counter;
  logic              csRise;
  logic              csFall;

  assign csRise = cs & ~csQ;
  assign csFall = ~cs & csQ;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      csQ         <= 1'b0;
      busyArmed   <= 1'b0;
      counter     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      buf_sel     <= 1'b0;
      accel_start <= 1'b0;
      frame_valid <= 1'b0;
      err         <= '0;
    end else begin
      csQ         <= cs;
      mem_we      <= 1'b0;
      accel_start <= 1'b0;

      case (state)
        IDLE: begin
          if (csRise) state <= CMD;
        end

        // A byte arriving with cs_fall is decoded first; the fall then applies to the decoded state.
        CMD: begin
          if (byte_valid) begin
            case (byte_data)
              CMD_LOAD: begin
                frame_valid <= 1'b0;
                counter     <= '0;
                if (csFall) begin
                  err[ERR_SHORT_FRAME] <= 1'b1;
                  state                <= IDLE;
                end else begin
                  state <= LOAD;
                end
              end
              CMD_START: begin
                if (frame_valid) begin
                  state <= START;
                end else begin
                  err[ERR_BAD_CMD] <= 1'b1;
                  state            <= csFall ? IDLE : DRAIN;
                end
              end
              CMD_CLRERR: begin
                err   <= '0;
                state <= csFall ? IDLE : DRAIN;
              end
              default: begin
                err[ERR_BAD_CMD] <= 1'b1;
                state            <= csFall ? IDLE : DRAIN;
              end
            endcase
          end else if (csFall) begin
            state <= IDLE;
          end
        end

        LOAD: begin
          if (byte_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= counter;
            mem_wdata <= byte_data;
            counter   <= counter + 1'b1;
            if (counter == LAST_PIX) begin
              frame_valid <= 1'b1;
              state       <= csFall ? IDLE : DRAIN;
            end else if (csFall) begin
              err[ERR_SHORT_FRAME] <= 1'b1;
              counter              <= '0;
              state                <= IDLE;
            end
          end else if (csFall) begin
            err[ERR_SHORT_FRAME] <= 1'b1;
            counter              <= '0;
            state                <= IDLE;
          end
        end

        DRAIN: begin
          if (csFall) state <= IDLE;
        end

        START: begin
          accel_start <= 1'b1;
          buf_sel     <= 1'b1;
          busyArmed   <= csRise;
          state       <= BUSY;
        end

        // Only a transaction opened while busy is flagged; leftovers of the START transaction are not.
        BUSY: begin
          if (csRise) busyArmed <= 1'b1;
          if (busyArmed && byte_valid) begin
            err[ERR_BUSY_CMD] <= 1'b1;
            busyArmed         <= 1'b0;
          end
          if (csFall) busyArmed <= 1'b0;
          if (accel_done) begin
            buf_sel   <= 1'b0;
            busyArmed <= 1'b0;
            state     <= cs ? DRAIN : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed and randomized transactions for spi_frame_loader (4x4 image), checked against a
// transaction-level model of commands, frame contents, error flags and buffer ownership.
module tb_spi_frame_loader;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 4;
  localparam int PIX    = IMG_W * IMG_H;

  logic              clk;
  logic              nrst;
  logic              cs;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              accel_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              buf_sel;
  logic              accel_start;
  logic              frame_valid;
  logic [2:0]        err;

  spi_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .nrst(nrst), .cs(cs), .byte_valid(byte_valid), .byte_data(byte_data),
    .accel_done(accel_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .buf_sel(buf_sel), .accel_start(accel_start), .frame_valid(frame_valid), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write port activity and start pulses, logged once per cycle.
  logic [31:0] wrA[$];
  logic [31:0] wrD[$];
  int          wrC[$];
  int          startCnt = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wrA.push_back(32'(mem_addr));
      wrD.push_back(32'(mem_wdata));
      wrC.push_back(cyc);
    end
    if (accel_start === 1'b1) startCnt <= startCnt + 1;
  end

  int total = 0;
  int bad   = 0;

  // Model state: frame resident, sticky errors {busy,short,bad}, accelerator owns buffer.
  logic       mFv;
  logic [2:0] mErr;
  logic       mBusy;

  logic [7:0]  txq[$];
  int          byteCyc[$];
  logic [31:0] expA[$];
  logic [31:0] expD[$];
  int          expC[$];
  int          expStart;
  int          wrBase;
  int          startBase;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkOuts0(input string tag);
    chk({tag, ".mem_we"},      32'(mem_we),      32'd0);
    chk({tag, ".mem_addr"},    32'(mem_addr),    32'd0);
    chk({tag, ".mem_wdata"},   32'(mem_wdata),   32'd0);
    chk({tag, ".buf_sel"},     32'(buf_sel),     32'd0);
    chk({tag, ".accel_start"}, 32'(accel_start), 32'd0);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, ".err"},         32'(err),         32'd0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    byteCyc.push_back(cyc);
    tick();
    byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // One chip-select transaction carrying txq; coinc drops cs together with the last byte.
  task automatic runTxn(input bit coinc);
    wrBase    = wrA.size();
    startBase = startCnt;
    byteCyc.delete();
    cs = 1'b1;
    tick();
    tick();
    foreach (txq[i]) begin
      if (coinc && i == txq.size() - 1) cs = 1'b0;
      sendByte(txq[i], $urandom_range(0, 2));
    end
    if (!coinc) begin
      tick();
      cs = 1'b0;
    end
    repeat (4) tick();
  endtask

  // Whole-transaction reference: what the command means for the frame, flags and ownership.
  task automatic model();
    int n;
    expA.delete();
    expD.delete();
    expC.delete();
    expStart = 0;
    if (txq.size() == 0) return;
    if (mBusy) begin
      mErr[2] = 1'b1;
      return;
    end
    case (txq[0])
      8'h01: begin
        mFv = 1'b0;
        n = (txq.size() - 1 < PIX) ? txq.size() - 1 : PIX;
        for (int k = 0; k < n; k++) begin
          expA.push_back(32'(k));
          expD.push_back(32'(txq[k+1]));
          expC.push_back(byteCyc[k+1] + 1);
        end
        if (txq.size() - 1 >= PIX) mFv = 1'b1;
        else mErr[1] = 1'b1;
      end
      8'h02: begin
        if (mFv) begin
          expStart = 1;
          mBusy    = 1'b1;
        end else begin
          mErr[0] = 1'b1;
        end
      end
      8'h03:   mErr = 3'b000;
      default: mErr[0] = 1'b1;
    endcase
  endtask

  task automatic verify(input string tag);
    int nObs;
    nObs = wrA.size() - wrBase;
    chk({tag, ".nwrites"}, 32'(nObs), 32'(expA.size()));
    for (int i = 0; i < nObs && i < expA.size(); i++) begin
      chk({tag, ".addr"},    wrA[wrBase+i], expA[i]);
      chk({tag, ".data"},    wrD[wrBase+i], expD[i]);
      chk({tag, ".latency"}, 32'(wrC[wrBase+i]), 32'(expC[i]));
    end
    chk({tag, ".starts"},      32'(startCnt - startBase), 32'(expStart));
    chk({tag, ".err"},         32'(err),         32'(mErr));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(mFv));
    chk({tag, ".buf_sel"},     32'(buf_sel),     32'(mBusy));
  endtask

  task automatic doTxn(input bit coinc, input string tag);
    runTxn(coinc);
    model();
    verify(tag);
  endtask

  task automatic accelDone(input string tag);
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    tick();
    mBusy = 1'b0;
    chk({tag, ".buf_sel"},     32'(buf_sel),     32'd0);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(mFv));
    chk({tag, ".err"},         32'(err),         32'(mErr));
  endtask

  task automatic fillLoad(input int npix, input bit ordered);
    txq.delete();
    txq.push_back(8'h01);
    for (int k = 0; k < npix; k++) txq.push_back(ordered ? 8'(k) : 8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] b;
    int r;
    nrst = 1'b0; cs = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; accel_done = 1'b0;
    mFv = 1'b0; mErr = 3'b000; mBusy = 1'b0;
    repeat (2) tick();
    chkOuts0("reset");
    nrst = 1'b1;
    tick();

    fillLoad(PIX, 1'b1);
    doTxn(1'b0, "load_seq");

    // Asynchronous reset in the middle of a load, then a clean load from address 0.
    cs = 1'b1;
    tick();
    tick();
    sendByte(8'h01, 0);
    for (int k = 0; k < 5; k++) sendByte(8'(8'h50 + k), 0);
    #2 nrst = 1'b0;
    #1 chkOuts0("reset_mid_load");
    mFv = 1'b0; mErr = 3'b000; mBusy = 1'b0;
    cs = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    fillLoad(PIX, 1'b0);
    doTxn(1'b0, "load_after_reset");

    txq = {8'h01, 8'hAA, 8'hBB, 8'hCC};
    doTxn(1'b0, "short_frame");
    txq = {8'h02};
    doTxn(1'b0, "start_no_frame");
    txq = {8'h03};
    doTxn(1'b0, "clrerr1");

    fillLoad(PIX, 1'b0);
    doTxn(1'b0, "load_for_start");
    accelDone("done_while_idle");
    txq = {8'h02, 8'h11};
    doTxn(1'b0, "start");
    fillLoad(4, 1'b0);
    doTxn(1'b0, "load_while_busy");
    accelDone("accel_done");

    txq = {8'h7E};
    doTxn(1'b0, "bad_cmd");
    txq = {8'h03};
    doTxn(1'b0, "clrerr2");
    fillLoad(PIX + 1, 1'b0);
    doTxn(1'b0, "load_17");
    fillLoad(PIX, 1'b0);
    doTxn(1'b1, "load_last_with_csfall");

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        fillLoad(($urandom_range(0, 1) == 1) ? PIX + $urandom_range(0, 2) : $urandom_range(0, PIX - 1), 1'b0);
        doTxn($urandom_range(0, 3) == 0, "rnd_load");
      end else if (r <= 5) begin
        txq = {8'h02};
        if ($urandom_range(0, 1) == 1) txq.push_back(8'($urandom_range(0, 255)));
        doTxn($urandom_range(0, 3) == 0, "rnd_start");
      end else if (r == 6) begin
        txq = {8'h03};
        doTxn($urandom_range(0, 3) == 0, "rnd_clrerr");
      end else if (r == 7) begin
        b = 8'($urandom_range(0, 255));
        if (b >= 8'h01 && b <= 8'h03) b = 8'hFF;
        txq = {b};
        doTxn($urandom_range(0, 3) == 0, "rnd_badcmd");
      end else if (r == 8) begin
        txq.delete();
        doTxn(1'b0, "rnd_empty");
      end else begin
        accelDone("rnd_done");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
